imem_resp: RTL and testbench
============================

// Module: imem_resp
// PURPOSE
//  Instruction-memory responder: the memory-side end of the fetch interface used by the IFU.
//  Accepts one fetch request at a time and returns the addressed 32-bit word after a fixed,
//  parameterised number of wait states; flags misaligned/out-of-range fetches.
//  Replaces the combinational imem in the single-cycle core for multi-cycle/latency studies.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words in the internal array
//  WAIT_STATES  2              extra cycles between accept and response (0 legal)
//  BASE_ADDR    32'h0000_0000  byte address of word 0
// PORTS
//  clock       in   1   system clock; all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   fetch request present
//  req_addr    in   32  byte address of requested instruction
//  flush       in   1   abort outstanding fetch (taken branch/jump)
//  req_ready   out  1   responder accepts a request this cycle
//  resp_valid  out  1   resp_* valid; one-cycle pulse per accepted, unflushed request
//  resp_inst   out  32  fetched instruction (32'h0 = NOP on error)
//  resp_addr   out  32  echo of accepted req_addr
//  resp_err    out  1   accepted address was misaligned or out of range
// BEHAVIOUR
//  - Reset: state=IDLE, wait_cnt=0, resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0;
//    req_ready=0 while reset high. Array contents untouched by reset (loaded via $readmemh
//    on the internal array, hierarchical name <inst>.u_array.mem).
//  - Handshake: transfer when req_valid & req_ready at posedge. req_ready = ~reset & ~flush &
//    (state==IDLE | state==RESP). Requester holds req_addr only during the accept cycle.
//  - FSM IDLE/WAIT/RESP:
//    IDLE: on accept capture addr; WAIT_STATES>0 -> WAIT (wait_cnt=WAIT_STATES-1), else -> RESP.
//    WAIT: wait_cnt decrements each cycle; at 0 -> RESP. flush -> IDLE, no response produced.
//    RESP: resp_valid=1 exactly this cycle. Accept here -> new transaction (same as IDLE
//          transitions); no accept -> IDLE.
//  - Latency: accept at cycle N -> resp_valid at N+WAIT_STATES+1. Back-to-back throughput:
//    one response per WAIT_STATES+1 cycles.
//  - resp_inst/resp_addr/resp_err registered, valid only while resp_valid; hold last value
//    otherwise.
//  - Address check on accepted addr: off = req_addr - BASE_ADDR (32-bit, wraps);
//    err if off[1:0]!=0 or off[31:2] >= DEPTH_WORDS. On err resp_inst=32'h0, resp_err=1;
//    array not read. Otherwise resp_inst = mem[off[31:2]].
//  - Simultaneous flush + RESP: the response already in RESP is still presented (IFU drops it);
//    flush blocks any new accept that cycle. flush in IDLE: no effect beyond req_ready=0.
//  - Reset mid-operation (WAIT or RESP): transaction discarded; resp_valid=0 next cycle.
//  - No performance counters; no multiple outstanding requests.
// STRUCTURE
//  - Shared header mips_defs.vh: FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2),
//    NOP_INST=32'h0, INST_W=32.
//  - One sub-module imem_array: DEPTH_WORDS x 32 storage, combinational read port
//    (word index in, data out), $readmemh target "mem". FSM, counter, address check in top.
//  - wait_cnt width = $clog2(WAIT_STATES+1), minimum 1 bit.
// TESTING (WAIT_STATES=2, DEPTH_WORDS=1024, BASE_ADDR=0; hex: mem[0]=20080005, mem[1]=01095020)
//  1 reset high 2 cycles, req_valid=1 -> req_ready=0, resp_valid=0, all resp_* = 0; after
//    release req_ready=1 next cycle.
//  2 accept addr 0 at cycle N -> resp_valid=1 only at N+3, resp_inst=20080005, resp_addr=0,
//    resp_err=0.
//  3 accept addr 4 in RESP cycle of previous fetch -> resp_inst=01095020 exactly 3 cycles later;
//    no idle gap in req_ready.
//  4 addr 32'h2 -> resp_err=1, resp_inst=0 at N+3; addr 32'h1000 (=4*DEPTH) -> resp_err=1.
//  5 flush during WAIT (cycle N+1) -> no resp_valid at N+3, req_ready=1 from N+2; reset at
//    N+1 -> same, state IDLE.
//  6 rebuild WAIT_STATES=0: accept at N -> resp_valid at N+1; continuous req_valid ->
//    response every cycle, addresses 0,4,8 in order.

Source files
------------

// File: rtl/imem_resp_pkg.sv
// -----------------------------------------------------------------------------
// imem_resp_pkg
//   Shared definitions for the instruction-memory responder: instruction width,
//   the NOP returned on a faulting fetch, the responder FSM encoding and the
//   fetch-address legality check.
// -----------------------------------------------------------------------------
package imem_resp_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // off is the byte offset from the array base (already wrapped to 32 bits).
   // A fetch faults when it is not word aligned or falls past the last word.
   function automatic logic addr_err(input logic [31:0] off, input int unsigned depth);
      return (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
//   DEPTH_WORDS x 32-bit instruction storage with a combinational read port.
//   Contents are never reset; they are expected to be preloaded into "mem"
//   by the environment. The synchronous write port is a patch/preload path;
//   the responder ties it off.
// Ports
//   clock    in            write clock
//   wr_en    in            write strobe
//   wr_idx   in  [AW-1:0]  write word index
//   wr_data  in  [31:0]    write data
//   rd_idx   in  [AW-1:0]  read word index
//   rd_data  out [31:0]    mem[rd_idx]
// -----------------------------------------------------------------------------
module imem_array
   import imem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_idx,
   input  logic [INST_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [INST_W-1:0] rd_data
);

   logic [INST_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_resp.sv
// -----------------------------------------------------------------------------
// imem_resp
//   Memory-side end of the IFU fetch interface. Accepts one fetch at a time and
//   returns the addressed word WAIT_STATES+1 cycles after the accept, flagging
//   misaligned / out-of-range fetches (those return NOP and never touch the
//   array). A flush during the wait aborts the fetch without a response.
// Ports
//   clock       in        system clock
//   reset       in        synchronous, active-high reset
//   req_valid   in        fetch request present
//   req_addr    in  [31:0] byte address (only held during the accept cycle)
//   flush       in        abort outstanding fetch, block new accepts
//   req_ready   out       request accepted this cycle if req_valid
//   resp_valid  out       one-cycle pulse per accepted, unflushed request
//   resp_inst   out [31:0] fetched word (NOP on error)
//   resp_addr   out [31:0] echo of the accepted address
//   resp_err    out       accepted address faulted
// -----------------------------------------------------------------------------
module imem_resp
   import imem_resp_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [31:0]       req_addr,
   input  logic              flush,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [INST_W-1:0] resp_inst,
   output logic [31:0]       resp_addr,
   output logic              resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [INST_W-1:0] resp_inst_q, resp_inst_d;
   logic [31:0]       resp_addr_q;
   logic              resp_err_q;

   logic              accept;
   logic              load_resp;
   logic [31:0]       src_addr;
   logic [31:0]       src_off;
   logic              src_err;
   logic [AW-1:0]     rd_idx;
   logic [INST_W-1:0] rd_data;

   assign req_ready = ~reset & ~flush & ((state_q == IDLE) | (state_q == RESP));
   assign accept    = req_valid & req_ready;

   // The response is formed on the cycle that enters RESP: from the captured
   // address when leaving WAIT, or straight from the bus when there are no
   // wait states and the accept goes directly to RESP.
   assign src_addr = (state_q == WAIT) ? addr_q : req_addr;
   assign src_off  = src_addr - BASE_ADDR;
   assign src_err  = addr_err(src_off, DEPTH_WORDS);
   assign rd_idx   = src_off[AW+1:2];

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clock   (clock),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_data ('0),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // Faulting fetches return NOP; the read data is discarded.
   assign resp_inst_d = src_err ? NOP_INST : rd_data;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      load_resp = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               addr_d = req_addr;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d   = RESP;
                  load_resp = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d   = RESP;
               load_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         resp_inst_q <= '0;
         resp_addr_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         // Response fields hold their last value between pulses.
         if (load_resp) begin
            resp_inst_q <= resp_inst_d;
            resp_addr_q <= src_addr;
            resp_err_q  <= src_err;
         end
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_inst  = resp_inst_q;
   assign resp_addr  = resp_addr_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_resp.sv
module tb_imem_resp;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      logic        err;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // WAIT_STATES=2 instance
   logic        req_valid, flush, req_ready, resp_valid, resp_err;
   logic [31:0] req_addr, resp_inst, resp_addr;
   // WAIT_STATES=0 instance
   logic        req_valid0, flush0, req_ready0, resp_valid0, resp_err0;
   logic [31:0] req_addr0, resp_inst0, resp_addr0;

   imem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .flush(flush), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_inst(resp_inst), .resp_addr(resp_addr), .resp_err(resp_err));

   imem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
      .clock(clock), .reset(reset), .req_valid(req_valid0), .req_addr(req_addr0),
      .flush(flush0), .req_ready(req_ready0), .resp_valid(resp_valid0),
      .resp_inst(resp_inst0), .resp_addr(resp_addr0), .resp_err(resp_err0));

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc0  = 0;
   logic [31:0] exp_mem [1024];
   exp_t q[$];
   exp_t q0[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input int c);
      exp_t e;
      e.addr = a;
      e.err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
      e.inst = e.err ? 32'h0 : exp_mem[a[11:2]];
      e.cyc  = c;
      return e;
   endfunction

   // Scoreboard push on every observed handshake
   always @(negedge clock) begin
      if (req_valid === 1'b1 && req_ready === 1'b1) q.push_back(model(req_addr, cyc + 3));
      if (req_valid0 === 1'b1 && req_ready0 === 1'b1) begin
         q0.push_back(model(req_addr0, cyc + 1));
         n_acc0++;
      end
   end

   // Scoreboard pop/compare on every response pulse
   always @(negedge clock) begin
      exp_t e;
      if (resp_valid === 1'b1) begin
         if (q.size() == 0) chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
         else begin
            e = q.pop_front();
            chk("inst", resp_inst, e.inst);
            chk("addr", resp_addr, e.addr);
            chk("err",  {31'b0, resp_err}, {31'b0, e.err});
            chk("lat",  cyc, e.cyc);
         end
      end
      if (resp_valid0 === 1'b1) begin
         if (q0.size() == 0) chk("spurious_resp0", {31'b0, resp_valid0}, 32'd0);
         else begin
            e = q0.pop_front();
            chk("inst0", resp_inst0, e.inst);
            chk("addr0", resp_addr0, e.addr);
            chk("err0",  {31'b0, resp_err0}, {31'b0, e.err});
            chk("lat0",  cyc, e.cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Present a request until accepted; returns the accept cycle (-1 on timeout).
   task automatic issue(input logic [31:0] a, output int acc);
      acc       = -1;
      req_valid = 1'b1;
      req_addr  = a;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (req_ready === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) chk("issue_timeout", {31'b0, req_ready}, 32'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hDEAD_BEEF;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, ax;
      exp_t dropped;
      reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0; flush = 1'b0;
      req_valid0 = 1'b0; req_addr0 = 32'h0; flush0 = 1'b0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = $urandom;
      exp_mem[0] = 32'h2008_0005;
      exp_mem[1] = 32'h0109_5020;
      for (int i = 0; i < 1024; i++) begin
         dut.u_array.mem[i]  = exp_mem[i];
         dut0.u_array.mem[i] = exp_mem[i];
      end

      // reset held for two cycles with a request pending
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk("rst_ready",  {31'b0, req_ready},  32'd0);
         chk("rst_valid",  {31'b0, resp_valid}, 32'd0);
         chk("rst_inst",   resp_inst, 32'd0);
         chk("rst_addr",   resp_addr, 32'd0);
         chk("rst_err",    {31'b0, resp_err}, 32'd0);
         chk("rst_ready0", {31'b0, req_ready0}, 32'd0);
      end
      step(1);
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clock);
      chk("post_rst_ready",  {31'b0, req_ready},  32'd1);
      chk("post_rst_ready0", {31'b0, req_ready0}, 32'd1);

      // basic fetch, then back-to-back fetch accepted in the RESP cycle
      issue(32'h0, a1);
      issue(32'h4, a2);
      chk("b2b_gap", a2 - a1, 32'd3);
      step(5);

      // faulting and boundary fetches
      issue(32'h2, ax);     step(5);
      issue(32'h1000, ax);  step(5);
      issue(32'hFFC, ax);   step(5);
      issue(32'hFFFF_FFFC, ax); step(5);

      // flush during WAIT
      issue(32'h8, ax);
      flush = 1'b1;
      dropped = q.pop_back();
      @(negedge clock);
      chk("flush_wait_ready", {31'b0, req_ready}, 32'd0);
      step(1);
      flush = 1'b0;
      @(negedge clock);
      chk("post_flush_ready", {31'b0, req_ready}, 32'd1);
      chk("post_flush_state", 32'(dut.state_q), 32'd0);
      step(4);

      // reset during WAIT
      issue(32'hC, ax);
      reset = 1'b1;
      dropped = q.pop_back();
      step(1);
      reset = 1'b0;
      chk("mid_rst_state", 32'(dut.state_q), 32'd0);
      @(negedge clock);
      chk("mid_rst_ready", {31'b0, req_ready},  32'd1);
      chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
      step(4);

      // flush in the RESP cycle: response still presented, new request blocked
      issue(32'h0, ax);
      step(2);
      flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
      @(negedge clock);
      chk("flush_resp_ready", {31'b0, req_ready},  32'd0);
      chk("flush_resp_valid", {31'b0, resp_valid}, 32'd1);
      step(1);
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clock);
      chk("after_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("after_resp_hold",  resp_addr, 32'h0);
      step(2);

      // flush while IDLE only drops req_ready
      flush = 1'b1;
      @(negedge clock);
      chk("flush_idle_ready", {31'b0, req_ready}, 32'd0);
      step(1);
      flush = 1'b0;
      @(negedge clock);
      chk("flush_idle_rel", {31'b0, req_ready}, 32'd1);

      // zero wait states: continuous stream 0,4,8
      step(1);
      req_valid0 = 1'b1; req_addr0 = 32'h0;
      step(1); req_addr0 = 32'h4;
      step(1); req_addr0 = 32'h8;
      step(1); req_valid0 = 1'b0;
      step(3);
      chk("b2b0_accepts", n_acc0, 32'd3);

      chk("pending",  q.size(),  32'd0);
      chk("pending0", q0.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
